// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the 7-segment display controller.
// Patterns are active-high, bit order g..a.
package seg7_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF  = 7'b0000000;
    localparam seg_t SEG_DASH = 7'b1000000;

    localparam seg_t SEG_DIGIT [0:9] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    function automatic seg_t apply_pol(seg_t s, logic act_low);
        return act_low ? ~s : s;
    endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// Single-digit BCD to segment decoder, active-high output.
// Overflow wins over blanking, blanking wins over the digit code.
module seg7_digit_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    input  logic       ovf_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        if (ovf_i) begin
            seg_o = SEG_DASH;
        end else if (blank_i) begin
            seg_o = SEG_OFF;
        end else if (nib_i <= 4'd9) begin
            seg_o = SEG_DIGIT[nib_i];
        end
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Two-stage capture/decode 7-segment controller with leading-zero blanking.
// Define SEG_SCAN_EN to add the multiplexed seg_mux/dig_sel scan outputs.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  blank_lz,
    input  logic                  ovf,
    input  logic [4*DIGITS-1:0]   cont,
    output logic [7*DIGITS-1:0]   seg_out,
    output logic                  disp_valid,
    output logic                  bad_code
`ifdef SEG_SCAN_EN
    ,
    output logic [6:0]            seg_mux,
    output logic [DIGITS-1:0]     dig_sel
`endif
);

    localparam logic ACT_LO = (ACTIVE_LOW != 0);
    localparam logic [7*DIGITS-1:0] SEG_RST = {7*DIGITS{ACT_LO}};

    logic [4*DIGITS-1:0] cont_q, cont_d;
    logic                ovf_q, ovf_d;
    logic                cap_v_q, cap_v_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic                dv_q;
    logic                bad_q, bad_d;
    logic [DIGITS-1:0]   blank_v;
    seg_t                dec [DIGITS];

    always_comb begin
        cont_d  = cont_q;
        ovf_d   = ovf_q;
        cap_v_d = cap_v_q;
        if (arm) begin
            cont_d  = cont;
            ovf_d   = ovf;
            cap_v_d = 1'b1;
        end
    end

    // A digit is blanked only while it and every digit above it are zero.
    always_comb begin
        logic seen;
        blank_v = '0;
        seen    = ~blank_lz;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (cont_q[4*k +: 4] != 4'd0) seen = 1'b1;
            blank_v[k] = ~seen;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_dec
        seg7_digit_dec u_dec (
            .nib_i   (cont_q[4*k +: 4]),
            .blank_i (blank_v[k]),
            .ovf_i   (ovf_q),
            .seg_o   (dec[k])
        );
    end

    always_comb begin
        seg_d = SEG_RST;
        bad_d = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            seg_d[7*k +: 7] = apply_pol(cap_v_q ? dec[k] : SEG_OFF, ACT_LO);
            if (cont_q[4*k +: 4] > 4'd9) bad_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cont_q  <= '0;
            ovf_q   <= 1'b0;
            cap_v_q <= 1'b0;
            seg_q   <= SEG_RST;
            dv_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            cont_q  <= cont_d;
            ovf_q   <= ovf_d;
            cap_v_q <= cap_v_d;
            seg_q   <= seg_d;
            dv_q    <= cap_v_q;
            bad_q   <= bad_d;
        end
    end

    assign seg_out    = seg_q;
    assign disp_valid = dv_q;
    assign bad_code   = bad_q;

`ifdef SEG_SCAN_EN
    localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIVW-1:0]   div_cnt_q, div_cnt_d;
    logic [IDXW-1:0]   dig_idx_q, dig_idx_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [6:0]        mux_q, mux_d;

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        dig_idx_d = dig_idx_q;
        if (div_cnt_q == DIVW'(SCAN_DIV - 1)) begin
            div_cnt_d = '0;
            if (dig_idx_q == IDXW'(DIGITS - 1)) begin
                dig_idx_d = '0;
            end else begin
                dig_idx_d = dig_idx_q + 1'b1;
            end
        end
    end

    // Select and segment slice come from the same index so they stay aligned.
    always_comb begin
        sel_d = '0;
        sel_d[dig_idx_q] = 1'b1;
        if (ACT_LO) sel_d = ~sel_d;
        mux_d = seg_q[7*int'(dig_idx_q) +: 7];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            dig_idx_q <= '0;
            sel_q     <= {DIGITS{ACT_LO}};
            mux_q     <= {7{ACT_LO}};
        end else begin
            div_cnt_q <= div_cnt_d;
            dig_idx_q <= dig_idx_d;
            sel_q     <= sel_d;
            mux_q     <= mux_d;
        end
    end

    assign seg_mux = mux_q;
    assign dig_sel = sel_q;
`endif

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Randomized self-checking bench for seg7_display_ctrl, default build.
// A behavioural model predicts outputs; directed literals pin the model.
module tb_seg7_display_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b1;
    logic        blank_lz = 1'b0;
    logic        ovf = 1'b0;
    logic [15:0] cont = 16'h1234;
    logic [27:0] seg_out;
    logic        disp_valid;
    logic        bad_code;

    int checks = 0;
    int failures = 0;

    seg7_display_ctrl #(.DIGITS(4), .ACTIVE_LOW(1), .SCAN_DIV(1000)) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .blank_lz   (blank_lz),
        .ovf        (ovf),
        .cont       (cont),
        .seg_out    (seg_out),
        .disp_valid (disp_valid),
        .bad_code   (bad_code)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Digit k is a leading zero iff the number formed by digits k and up is 0.
    function automatic logic [27:0] model_seg(logic [15:0] c, logic o,
                                              logic v, logic b);
        logic [27:0] r;
        logic [6:0]  p;
        int          nib;
        for (int k = 0; k < 4; k++) begin
            nib = int'((c >> (4 * k)) & 16'hF);
            if (!v) p = 7'b0;
            else if (o) p = 7'b1000000;
            else if (b && k > 0 && (c >> (4 * k)) == 16'h0) p = 7'b0;
            else p = glyph(nib);
            r[7*k +: 7] = ~p;
        end
        return r;
    endfunction

    function automatic logic model_bad(logic [15:0] c);
        for (int k = 0; k < 4; k++)
            if (((c >> (4 * k)) & 16'hF) > 16'd9) return 1'b1;
        return 1'b0;
    endfunction

    logic [15:0] m_c;
    logic        m_o, m_v;
    logic [27:0] e_seg;
    logic        e_dv, e_bad;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_c   <= '0;
            m_o   <= 1'b0;
            m_v   <= 1'b0;
            e_seg <= '1;
            e_dv  <= 1'b0;
            e_bad <= 1'b0;
        end else begin
            e_seg <= model_seg(m_c, m_o, m_v, blank_lz);
            e_dv  <= m_v;
            e_bad <= model_bad(m_c);
            if (arm) begin
                m_c <= cont;
                m_o <= ovf;
                m_v <= 1'b1;
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_seg_out", {4'h0, seg_out}, {4'h0, e_seg});
        check("model_disp_valid", {31'h0, disp_valid}, {31'h0, e_dv});
        check("model_bad_code", {31'h0, bad_code}, {31'h0, e_bad});
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [27:0] L1234 =
        {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    localparam logic [27:0] L0057 =
        {7'b1000000, 7'b1000000, 7'b0010010, 7'b1111000};
    localparam logic [27:0] L0057B =
        {7'b1111111, 7'b1111111, 7'b0010010, 7'b1111000};
    localparam logic [27:0] L0000B =
        {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
    localparam logic [27:0] L0A05B =
        {7'b1111111, 7'b1111111, 7'b1000000, 7'b0010010};
    localparam logic [27:0] LDASH = {4{7'b0111111}};

    initial begin
        tick();
        tick();
        check("rst_seg", {4'h0, seg_out}, {4'h0, 28'hFFFFFFF});
        check("rst_dv", {31'h0, disp_valid}, 32'h0);
        reset = 1'b0;
        tick();
        tick();
        check("lit_1234", {4'h0, seg_out}, {4'h0, L1234});
        check("lit_dv", {31'h0, disp_valid}, 32'h1);

        cont = 16'h0057;
        tick();
        arm = 1'b0;
        cont = 16'h9999;
        repeat (4) tick();
        check("lit_hold_0057", {4'h0, seg_out}, {4'h0, L0057});
        blank_lz = 1'b1;
        tick();
        check("lit_blank_0057", {4'h0, seg_out}, {4'h0, L0057B});

        arm = 1'b1;
        cont = 16'h0000;
        tick();
        tick();
        check("lit_blank_0000", {4'h0, seg_out}, {4'h0, L0000B});
        cont = 16'h0A05;
        tick();
        tick();
        check("lit_blank_0A05", {4'h0, seg_out}, {4'h0, L0A05B});
        check("lit_bad_0A05", {31'h0, bad_code}, 32'h1);

        blank_lz = 1'b0;
        ovf = 1'b1;
        cont = 16'h1234;
        tick();
        tick();
        check("lit_ovf_dash", {4'h0, seg_out}, {4'h0, LDASH});
        ovf = 1'b0;
        tick();
        tick();
        check("lit_ovf_clear", {4'h0, seg_out}, {4'h0, L1234});

        #2 reset = 1'b1;
        #1;
        check("lit_async_seg", {4'h0, seg_out}, {4'h0, 28'hFFFFFFF});
        check("lit_async_dv", {31'h0, disp_valid}, 32'h0);
        arm = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        arm = 1'b1;
        tick();
        check("lit_no_glitch", {4'h0, seg_out}, {4'h0, 28'hFFFFFFF});

        for (int i = 0; i < 400; i++) begin
            arm = ($urandom_range(0, 3) != 0);
            ovf = ($urandom_range(0, 7) == 0);
            blank_lz = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 0) begin
                cont = 16'($urandom);
            end else begin
                for (int k = 0; k < 4; k++)
                    cont[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 :
                                     4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b1;
                #1;
                check("rnd_async_seg", {4'h0, seg_out},
                      {4'h0, 28'hFFFFFFF});
                @(negedge clk);
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
